// File: rtl/oled_cmd_store_pkg.sv
// oled_cmd_store_pkg
//   Shared definitions for the OLED command store. It holds the store geometry,
//   the SSD1306 command codes, the load FSM states, the read-patch selector and
//   the default init table.
//   This file has no ports.
package oled_cmd_store_pkg;

  localparam int OLED_CMD_DEPTH = 32;
  localparam int OLED_ADDR_W    = 5;
  localparam int OLED_LOAD_LEN  = 28;

  localparam logic [OLED_ADDR_W-1:0] IDX_ENT  = 5'd23;
  localparam logic [OLED_ADDR_W-1:0] IDX_INV  = 5'd24;
  localparam logic [OLED_ADDR_W-1:0] IDX_DON  = 5'd27;
  localparam logic [OLED_ADDR_W-1:0] LAST_IDX = 5'd31;

  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_ENT_RAM  = 8'hA4;
  localparam logic [7:0] CMD_ENT_ON   = 8'hA5;
  localparam logic [7:0] CMD_NORMAL   = 8'hA6;
  localparam logic [7:0] CMD_INVERSE  = 8'hA7;
  localparam logic [7:0] CMD_NOP      = 8'hE3;

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_READY = 1'b1
  } oledState_e;

  typedef enum logic [1:0] {
    PATCH_NONE     = 2'd0,
    PATCH_ENT_ON   = 2'd1,
    PATCH_DISP_OFF = 2'd2,
    PATCH_INVERSE  = 2'd3
  } oledPatch_e;

  // Default SSD1306 power-up sequence. Entries past the table are padded with NOP
  // so that the sequencer can safely walk the whole store.
  function automatic logic [7:0] defaultCmd(input logic [OLED_ADDR_W-1:0] idx);
    logic [7:0] cmd;
    cmd = CMD_NOP;
    if (int'(idx) < OLED_LOAD_LEN) begin
      case (idx)
        5'd0:    cmd = CMD_DISP_OFF;
        5'd1:    cmd = 8'hD5;
        5'd2:    cmd = 8'h80;
        5'd3:    cmd = 8'hA8;
        5'd4:    cmd = 8'h3F;
        5'd5:    cmd = 8'hD3;
        5'd6:    cmd = 8'h00;
        5'd7:    cmd = 8'h40;
        5'd8:    cmd = 8'h8D;
        5'd9:    cmd = 8'h14;
        5'd10:   cmd = 8'h20;
        5'd11:   cmd = 8'h00;
        5'd12:   cmd = 8'hA1;
        5'd13:   cmd = 8'hC8;
        5'd14:   cmd = 8'hDA;
        5'd15:   cmd = 8'h12;
        5'd16:   cmd = 8'h81;
        5'd17:   cmd = 8'hCF;
        5'd18:   cmd = 8'hD9;
        5'd19:   cmd = 8'hF1;
        5'd20:   cmd = 8'hDB;
        5'd21:   cmd = 8'h40;
        5'd22:   cmd = 8'h2E;
        5'd23:   cmd = CMD_ENT_RAM;
        5'd24:   cmd = CMD_NORMAL;
        5'd25:   cmd = CMD_NOP;
        5'd26:   cmd = CMD_NOP;
        5'd27:   cmd = CMD_DISP_ON;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

  // Substitutes the display-mode command for the stored one on the way out.
  function automatic logic [7:0] applyPatch(input logic [7:0] stored, input oledPatch_e sel);
    logic [7:0] result;
    result = stored;
    case (sel)
      PATCH_ENT_ON:   result = CMD_ENT_ON;
      PATCH_DISP_OFF: result = CMD_DISP_OFF;
      PATCH_INVERSE:  result = CMD_INVERSE;
      default:        result = stored;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/oled_cmd_store_if.sv
// oled_cmd_store_if
//   Read/write bus between the command store and its users. The I2C sequencer
//   reads through it, and the host uses it for run-time writes.
//   The master modport is the sequencer/host side.
//   The slave modport is the command store.
//   Signals:
//     rd_en, rd_addr        read strobe and address
//     rd_data               registered, patched read data
//     wr_en, wr_addr, wr_data  host write
//     wr_err                one-cycle pulse when a write is rejected
//     ready                 the table is valid
interface oled_cmd_store_if;
  import oled_cmd_store_pkg::*;

  logic                   rd_en;
  logic [OLED_ADDR_W-1:0] rd_addr;
  logic [7:0]             rd_data;
  logic                   wr_en;
  logic [OLED_ADDR_W-1:0] wr_addr;
  logic [7:0]             wr_data;
  logic                   wr_err;
  logic                   ready;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, wr_err, ready
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, wr_err, ready
  );

endinterface

// File: rtl/oled_cmd_store_ram.sv
// oled_cmd_store_ram
//   A 32x8 single-clock command RAM. It has one write port and one synchronous
//   read port. A read and a write to the same address in the same cycle return
//   the old contents.
//   Ports:
//     clk      clock
//     we_i     write enable
//     waddr_i  write address
//     wdata_i  write data
//     re_i     read enable; the output register holds its value while re_i is low
//     raddr_i  read address
//     rdata_o  registered read data
module oled_cmd_store_ram
  import oled_cmd_store_pkg::*;
(
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [OLED_ADDR_W-1:0] waddr_i,
  input  logic [7:0]             wdata_i,
  input  logic                   re_i,
  input  logic [OLED_ADDR_W-1:0] raddr_i,
  output logic [7:0]             rdata_o
);

  logic [7:0] mem_q [OLED_CMD_DEPTH];
  logic [7:0] rdData_q;

  // The read samples the array before this edge's write lands, which gives
  // read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdData_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdData_q;

endmodule

// File: rtl/oled_cmd_store.sv
// oled_cmd_store
//   Command store that feeds the OLED I2C sequencer. After reset, or after a
//   reload, it copies the default SSD1306 init table into RAM. The host may
//   overwrite entries once the store is ready. Display-mode requests patch
//   selected entries as they are read; the stored contents are not changed.
//   Ports:
//     clk           clock
//     reset         synchronous, active-low
//     bus           slave side of the read/write bus
//     reload_i      a rising edge restarts the default load
//     mode_white_i  all-white request; reads of the entire-display entry return A5
//     mode_black_i  all-black request; reads of the display-on entry return AE
//     mode_inv_i    inverse request; reads of the normal/inverse entry return A7
module oled_cmd_store
  import oled_cmd_store_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  oled_cmd_store_if.slave   bus,
  input  logic              reload_i,
  input  logic              mode_white_i,
  input  logic              mode_black_i,
  input  logic              mode_inv_i
);

  oledState_e             state_q, state_d;
  logic [OLED_ADDR_W-1:0] loadCnt_q, loadCnt_d;
  logic                   reload_q;
  logic                   wrErr_q;
  logic                   rdValid_q;
  oledPatch_e             patchSel_q, patchSel_d;

  logic                   ready;
  logic                   reloadRise;
  logic                   readAccept;
  logic                   ramWe;
  logic [OLED_ADDR_W-1:0] ramWaddr;
  logic [7:0]             ramWdata;
  logic [7:0]             ramRdata;

  assign ready      = (state_q == ST_READY);
  assign reloadRise = reload_i & ~reload_q;
  assign readAccept = bus.rd_en & ready;

  // Load FSM and the RAM write-port mux. While loading, the counter owns the
  // write port and host writes are dropped. Once the store is ready, the host
  // owns the port. A reload edge still lets that cycle's host write through;
  // the load that follows then overwrites it.
  always_comb begin
    state_d   = state_q;
    loadCnt_d = loadCnt_q;
    ramWe     = 1'b0;
    ramWaddr  = bus.wr_addr;
    ramWdata  = bus.wr_data;
    case (state_q)
      ST_LOAD: begin
        ramWe    = 1'b1;
        ramWaddr = loadCnt_q;
        ramWdata = defaultCmd(loadCnt_q);
        if (loadCnt_q == LAST_IDX) begin
          state_d   = ST_READY;
          loadCnt_d = '0;
        end else begin
          loadCnt_d = loadCnt_q + 5'd1;
        end
      end
      ST_READY: begin
        ramWe = bus.wr_en;
        if (reloadRise) begin
          state_d   = ST_LOAD;
          loadCnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_LOAD;
        loadCnt_d = '0;
      end
    endcase
    if (!reset) begin
      ramWe = 1'b0;
    end
  end

  // The patch is chosen from the mode inputs in the cycle the read is accepted.
  // It is applied to the RAM output one cycle later.
  always_comb begin
    patchSel_d = PATCH_NONE;
    if ((bus.rd_addr == IDX_ENT) && mode_white_i) begin
      patchSel_d = PATCH_ENT_ON;
    end else if ((bus.rd_addr == IDX_DON) && mode_black_i && !mode_white_i) begin
      patchSel_d = PATCH_DISP_OFF;
    end else if ((bus.rd_addr == IDX_INV) && mode_inv_i && !mode_white_i && !mode_black_i) begin
      patchSel_d = PATCH_INVERSE;
    end
  end

  // rdValid_q forces rd_data to zero from reset until the first accepted read.
  // The RAM output register holds the last read, so rd_data stays stable
  // between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_LOAD;
      loadCnt_q  <= '0;
      reload_q   <= reload_i;
      wrErr_q    <= 1'b0;
      rdValid_q  <= 1'b0;
      patchSel_q <= PATCH_NONE;
    end else begin
      state_q   <= state_d;
      loadCnt_q <= loadCnt_d;
      reload_q  <= reload_i;
      wrErr_q   <= bus.wr_en & ~ready;
      if (readAccept) begin
        rdValid_q  <= 1'b1;
        patchSel_q <= patchSel_d;
      end
    end
  end

  oled_cmd_store_ram u_ram (
    .clk     (clk),
    .we_i    (ramWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .re_i    (readAccept),
    .raddr_i (bus.rd_addr),
    .rdata_o (ramRdata)
  );

  assign bus.rd_data = rdValid_q ? applyPatch(ramRdata, patchSel_q) : 8'h00;
  assign bus.wr_err  = wrErr_q;
  assign bus.ready   = ready;

endmodule

// File: tb/tb_oled_cmd_store.sv
// tb_oled_cmd_store
//   Scoreboard bench for oled_cmd_store. Stimulus tasks push expected read data,
//   taken from a table-level reference model, into a queue. A monitor pops the
//   queue and compares one cycle after each read strobe.
module tb_oled_cmd_store;

  typedef struct {
    logic [7:0] data;
    logic [4:0] addr;
  } exp_t;

  localparam logic [7:0] INIT_TABLE [0:27] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'h2E, 8'hA4,
    8'hA6, 8'hE3, 8'hE3, 8'hAF
  };

  logic clk = 1'b0;
  logic reset;
  logic reload;
  logic modeWhite, modeBlack, modeInv;

  oled_cmd_store_if bus();

  oled_cmd_store dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .reload_i     (reload),
    .mode_white_i (modeWhite),
    .mode_black_i (modeBlack),
    .mode_inv_i   (modeInv)
  );

  always #5 clk = ~clk;

  int         passCount  = 0;
  int         checkCount = 0;
  int         cyc        = 0;
  int         releaseCyc = 0;
  logic [7:0] model [32];
  bit         modelReady = 1'b0;
  logic [7:0] heldRd     = 8'h00;
  exp_t       expQ [$];
  logic       rdFire;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the default table, then the patch rules applied to whatever
  // value is currently stored.
  function automatic logic [7:0] refDefault(input int idx);
    if (idx < 28) return INIT_TABLE[idx];
    return 8'hE3;
  endfunction

  function automatic logic [7:0] refRead(input int a, input logic [7:0] stored,
                                         input bit w, input bit b, input bit i);
    if (a == 23 && w) return 8'hA5;
    if (a == 27 && b && !w) return 8'hAE;
    if (a == 24 && i && !w && !b) return 8'hA7;
    return stored;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
  endtask

  // Monitor: fires one cycle after every read strobe, whether or not the
  // store accepted it.
  always @(posedge clk) rdFire <= bus.rd_en;

  always @(negedge clk) begin
    if (rdFire === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL scoreboard: got read data %0h, required no read outstanding", bus.rd_data);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("rd_data@%0d", e.addr), {24'h0, bus.rd_data}, {24'h0, e.data});
      end
    end
  end

  // One bus cycle: an optional read and an optional write, issued together.
  task automatic doAccess(input bit doRd, input logic [4:0] ra, input bit doWr,
                          input logic [4:0] wa, input logic [7:0] wd,
                          input bit w, input bit b, input bit i);
    exp_t e;
    bit   wasReady;
    @(negedge clk);
    bus.rd_en   = doRd;
    bus.rd_addr = ra;
    bus.wr_en   = doWr;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    modeWhite   = w;
    modeBlack   = b;
    modeInv     = i;
    if (doRd) begin
      if (modelReady) heldRd = refRead(int'(ra), model[ra], w, b, i);
      e.data = heldRd;
      e.addr = ra;
      expQ.push_back(e);
    end
    wasReady = modelReady;
    if (doWr && modelReady) model[wa] = wd;
    @(negedge clk);
    if (doWr) checkOutput("wr_err", {31'h0, bus.wr_err}, wasReady ? 32'd0 : 32'd1);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic doRead(input logic [4:0] a, input bit w, input bit b, input bit i);
    doAccess(1'b1, a, 1'b0, 5'd0, 8'h00, w, b, i);
  endtask

  task automatic doWrite(input logic [4:0] a, input logic [7:0] d);
    doAccess(1'b0, 5'd0, 1'b1, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset       = 1'b0;
    reload      = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    modeWhite   = 1'b0;
    modeBlack   = 1'b0;
    modeInv     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_rd_data", {24'h0, bus.rd_data}, 32'h0);
    checkOutput("reset_ready", {31'h0, bus.ready}, 32'd0);
    checkOutput("reset_wr_err", {31'h0, bus.wr_err}, 32'd0);
    reset      = 1'b1;
    releaseCyc = cyc;
    modelReady = 1'b0;
    heldRd     = 8'h00;
    for (int k = 0; k < 32; k++) model[k] = refDefault(k);
  endtask

  // Waits with a bound for ready, then checks how many clocks it took from fromCyc.
  task automatic waitReady(input string name, input int fromCyc);
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, cyc - fromCyc, 32'd32);
    modelReady = 1'b1;
  endtask

  task automatic applyStimulus(input int count);
    for (int k = 0; k < count; k++) begin
      int         op;
      logic [4:0] ra, wa;
      logic [7:0] wd;
      op = $urandom_range(0, 3);
      ra = 5'($urandom_range(0, 31));
      wa = 5'($urandom_range(0, 31));
      wd = 8'($urandom_range(0, 255));
      case (op)
        0: doRead(ra, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        1: doWrite(wa, wd);
        2: doAccess(1'b1, ra, 1'b1, ra, wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        default: doAccess(1'b1, ra, 1'b1, wa, wd, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      endcase
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got simulation still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dropCyc;
    int n;
    reset       = 1'b0;
    reload      = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    modeWhite   = 1'b0;
    modeBlack   = 1'b0;
    modeInv     = 1'b0;

    $display("[TB] power-up load and table scan");
    doReset();
    waitReady("ready_latency", releaseCyc);
    for (int a = 0; a < 32; a++) doRead(5'(a), 1'b0, 1'b0, 1'b0);

    $display("[TB] host write and read-before-write");
    doWrite(5'd17, 8'h8F);
    doRead(5'd17, 1'b0, 1'b0, 1'b0);
    doAccess(1'b1, 5'd17, 1'b1, 5'd17, 8'h10, 1'b0, 1'b0, 1'b0);
    doRead(5'd17, 1'b0, 1'b0, 1'b0);

    $display("[TB] display-mode patching");
    doRead(5'd23, 1'b1, 1'b1, 1'b0);
    doRead(5'd27, 1'b1, 1'b1, 1'b0);
    doRead(5'd27, 1'b0, 1'b1, 1'b0);
    doRead(5'd24, 1'b0, 1'b0, 1'b1);
    doRead(5'd24, 1'b0, 1'b1, 1'b1);
    doRead(5'd23, 1'b0, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    applyStimulus(150);

    $display("[TB] reload with coincident write");
    doWrite(5'd0, 8'hAF);
    doRead(5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reload      = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 8'h55;
    model[3]    = 8'h55;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checkOutput("reload_wr_err", {31'h0, bus.wr_err}, 32'd0);
    checkOutput("reload_ready_drop", {31'h0, bus.ready}, 32'd0);
    n = 0;
    while (bus.ready !== 1'b0 && n < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    dropCyc    = cyc;
    modelReady = 1'b0;
    for (int k = 0; k < 32; k++) model[k] = refDefault(k);
    waitReady("reload_latency", dropCyc);
    reload = 1'b0;
    doRead(5'd0, 1'b0, 1'b0, 1'b0);
    doRead(5'd3, 1'b0, 1'b0, 1'b0);

    $display("[TB] writes and reads while loading");
    doReset();
    doWrite(5'd5, 8'h3F);
    @(negedge clk);
    checkOutput("wr_err_pulse_end", {31'h0, bus.wr_err}, 32'd0);
    doRead(5'd5, 1'b0, 1'b0, 1'b0);
    waitReady("ready_latency_after_drop", releaseCyc);
    doRead(5'd5, 1'b0, 1'b0, 1'b0);

    $display("[TB] reset in the middle of the load");
    doReset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset      = 1'b1;
    releaseCyc = cyc;
    checkOutput("ready_after_midload_reset", {31'h0, bus.ready}, 32'd0);
    waitReady("ready_latency_midload", releaseCyc);
    doRead(5'd27, 1'b0, 1'b0, 1'b0);
    doRead(5'd31, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drain", expQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
